// File: rtl/dvi_mode_ctrl.sv
// Mode controller for the DVI timing generator: holds the video mode table and
// sequences glitch-free mode changes (frame align, generator reset hold, blanking).
module dvi_mode_ctrl #(
    parameter int unsigned DEFAULT_MODE  = 0,
    parameter int unsigned SETTLE_CYC    = 8,
    parameter logic [23:0] FRAME_TIMEOUT = 24'd2_000_000
) (
    input  logic        i_pix_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [1:0]  i_mode,
    input  logic        i_frame,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_timeout,
    output logic [1:0]  o_mode,
    output logic        o_tg_rst,
    output logic        o_blank,
    output logic [15:0] o_h_res,
    output logic [15:0] o_h_fp,
    output logic [15:0] o_h_sync,
    output logic [15:0] o_h_bp,
    output logic [15:0] o_v_res,
    output logic [15:0] o_v_fp,
    output logic [15:0] o_v_sync,
    output logic [15:0] o_v_bp,
    output logic        o_h_pol,
    output logic        o_v_pol
);

    localparam int unsigned TW = 16;
    localparam logic [1:0]  DEF_MODE    = 2'(DEFAULT_MODE);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [23:0] WAIT_LAST   = FRAME_TIMEOUT - 24'd1;

    typedef struct packed {
        logic [TW-1:0] h_res;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_res;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_bp;
        logic          h_pol;
        logic          v_pol;
    } timing_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRM,
        S_LOAD,
        S_SETTLE,
        S_WAIT_FIRST
    } state_t;

    // Video mode table
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33, 1'b0, 1'b0};
            2'd1:    t = '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23, 1'b1, 1'b1};
            2'd2:    t = '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720, 16'd5,  16'd5, 16'd20, 1'b1, 1'b1};
            default: t = '{16'd1024, 16'd24,  16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29, 1'b0, 1'b0};
        endcase
        return t;
    endfunction

    state_t      state, state_nxt;
    logic [1:0]  mode_req, mode_req_nxt;
    logic [23:0] wcnt, wcnt_nxt;
    logic [7:0]  scnt, scnt_nxt;
    logic        ready_nxt, done_nxt, timeout_nxt, tg_rst_nxt, blank_nxt;
    logic        load;
    timing_t     tim;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt    = state;
        mode_req_nxt = mode_req;
        wcnt_nxt     = wcnt;
        scnt_nxt     = scnt;
        ready_nxt    = 1'b0;
        done_nxt     = 1'b0;
        timeout_nxt  = o_timeout;
        tg_rst_nxt   = o_tg_rst;
        blank_nxt    = o_blank;
        load         = 1'b0;

        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                if (i_req) begin
                    mode_req_nxt = i_mode;
                    timeout_nxt  = 1'b0;
                    wcnt_nxt     = '0;
                    ready_nxt    = 1'b0;
                    state_nxt    = S_WAIT_FRM;
                end
            end
            S_WAIT_FRM: begin
                if (i_frame) begin
                    load = 1'b1;
                end else if (wcnt == WAIT_LAST) begin
                    load        = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 24'd1;
                end
            end
            S_LOAD: begin
                scnt_nxt  = 8'd1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                // LOAD cycle counts as the first reset-hold cycle
                if (scnt == SETTLE_LAST) begin
                    tg_rst_nxt = 1'b0;
                    state_nxt  = S_WAIT_FIRST;
                end else begin
                    scnt_nxt = scnt + 8'd1;
                end
            end
            S_WAIT_FIRST: begin
                if (i_frame) begin
                    blank_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (load) begin
            tg_rst_nxt = 1'b1;
            blank_nxt  = 1'b1;
            scnt_nxt   = '0;
            state_nxt  = S_LOAD;
        end
    end

    // State and output registers; reset lands directly in a loaded default mode
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_LOAD;
            mode_req  <= DEF_MODE;
            wcnt      <= '0;
            scnt      <= '0;
            o_ready   <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            o_tg_rst  <= 1'b1;
            o_blank   <= 1'b1;
            o_mode    <= DEF_MODE;
            tim       <= mode_timing(DEF_MODE);
        end else begin
            state     <= state_nxt;
            mode_req  <= mode_req_nxt;
            wcnt      <= wcnt_nxt;
            scnt      <= scnt_nxt;
            o_ready   <= ready_nxt;
            o_done    <= done_nxt;
            o_timeout <= timeout_nxt;
            o_tg_rst  <= tg_rst_nxt;
            o_blank   <= blank_nxt;
            if (load) begin
                o_mode <= mode_req;
                tim    <= mode_timing(mode_req);
            end
        end
    end

    assign o_h_res  = tim.h_res;
    assign o_h_fp   = tim.h_fp;
    assign o_h_sync = tim.h_sync;
    assign o_h_bp   = tim.h_bp;
    assign o_v_res  = tim.v_res;
    assign o_v_fp   = tim.v_fp;
    assign o_v_sync = tim.v_sync;
    assign o_v_bp   = tim.v_bp;
    assign o_h_pol  = tim.h_pol;
    assign o_v_pol  = tim.v_pol;

endmodule

// File: tb/tb_dvi_mode_ctrl.sv
// Directed self-checking bench for dvi_mode_ctrl: reset, mode change, timeout,
// ignored requests, mid-sequence reset and steady-state mode 1.
module tb_dvi_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        frame = 1'b0;
    logic        ready, done, timeout, tg_rst, blank, h_pol, v_pol;
    logic [1:0]  cur_mode;
    logic [15:0] h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp;
    logic [129:0] act;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvi_mode_ctrl #(
        .DEFAULT_MODE (0),
        .SETTLE_CYC   (8),
        .FRAME_TIMEOUT(24'd1000)
    ) dut (
        .i_pix_clk(clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_mode   (mode),
        .i_frame  (frame),
        .o_ready  (ready),
        .o_done   (done),
        .o_timeout(timeout),
        .o_mode   (cur_mode),
        .o_tg_rst (tg_rst),
        .o_blank  (blank),
        .o_h_res  (h_res),
        .o_h_fp   (h_fp),
        .o_h_sync (h_sync),
        .o_h_bp   (h_bp),
        .o_v_res  (v_res),
        .o_v_fp   (v_fp),
        .o_v_sync (v_sync),
        .o_v_bp   (v_bp),
        .o_h_pol  (h_pol),
        .o_v_pol  (v_pol)
    );

    assign act = {h_res, h_fp, h_sync, h_bp, v_res, v_fp, v_sync, v_bp, h_pol, v_pol};

    function automatic logic [129:0] exp_t(input int m);
        case (m)
            0:       return {16'd640,  16'd16,  16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33, 1'b0, 1'b0};
            1:       return {16'd800,  16'd40,  16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23, 1'b1, 1'b1};
            2:       return {16'd1280, 16'd110, 16'd40,  16'd220, 16'd720, 16'd5,  16'd5, 16'd20, 1'b1, 1'b1};
            default: return {16'd1024, 16'd24,  16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns at the falling edge after the accepting edge
    task automatic request(input logic [1:0] m);
        @(negedge clk);
        req  = 1'b1;
        mode = m;
        @(negedge clk);
        req  = 1'b0;
    endtask

    // One-cycle frame tick; returns just after the edge that samples it
    task automatic frame_pulse();
        @(negedge clk);
        frame = 1'b1;
        @(posedge clk);
        #1;
        frame = 1'b0;
    endtask

    task automatic wait_settled();
        int n = 0;
        while (tg_rst === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tg_rst !== 1'b0) begin
            errors++;
            $display("FAIL settle_bound: tg_rst=%b after %0d cycles, required 0", tg_rst, n);
        end
    endtask

    task automatic test_reset();
        int n;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({tg_rst, blank, ready, done, timeout} !== 5'b11000) begin errors++;
            $display("FAIL reset_ctrl: tg/blank/ready/done/to=%b required 11000", {tg_rst, blank, ready, done, timeout}); end
        checks++; if (cur_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d required 0", cur_mode); end
        checks++; if (act !== exp_t(0)) begin errors++; $display("FAIL reset_timing: got %h required %h", act, exp_t(0)); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tg_rst) n++; else break;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL reset_settle_len: got %0d required 8", n); end
        repeat (5) step();
        checks++; if ({blank, ready} !== 2'b10) begin errors++; $display("FAIL reset_wait_first: blank/ready=%b required 10", {blank, ready}); end
        frame_pulse();
        checks++; if ({done, blank, ready} !== 3'b101) begin errors++; $display("FAIL reset_done: done/blank/ready=%b required 101", {done, blank, ready}); end
        step();
        checks++; if ({done, ready} !== 2'b01) begin errors++; $display("FAIL reset_done_pulse: done/ready=%b required 01", {done, ready}); end
    endtask

    task automatic test_mode_change();
        int n;
        request(2'd2);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mc_ready_drop: got %b required 0", ready); end
        repeat (99) step();
        checks++; if (act !== exp_t(0) || tg_rst !== 1'b0) begin errors++;
            $display("FAIL mc_wait_hold: timing %h tg %b required %h tg 0", act, tg_rst, exp_t(0)); end
        frame_pulse();
        checks++; if (act !== exp_t(2)) begin errors++; $display("FAIL mc_timing: got %h required %h", act, exp_t(2)); end
        checks++; if ({tg_rst, blank, cur_mode} !== 4'b1110) begin errors++;
            $display("FAIL mc_load: tg/blank/mode=%b required 1110", {tg_rst, blank, cur_mode}); end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tg_rst) n++; else break;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL mc_settle_len: got %0d required 8", n); end
        repeat (5) step();
        checks++; if ({blank, ready, done} !== 3'b100) begin errors++; $display("FAIL mc_blank_hold: blank/ready/done=%b required 100", {blank, ready, done}); end
        frame_pulse();
        checks++; if ({done, blank, ready, cur_mode} !== 5'b10110) begin errors++;
            $display("FAIL mc_done: done/blank/ready/mode=%b required 10110", {done, blank, ready, cur_mode}); end
    endtask

    task automatic test_timeout();
        int n = 0;
        request(2'd1);
        for (int i = 0; i < 2000; i++) begin
            step();
            n++;
            if (tg_rst) break;
        end
        checks++; if (n !== 1000) begin errors++; $display("FAIL to_latency: got %0d required 1000", n); end
        checks++; if ({timeout, cur_mode} !== 3'b101) begin errors++; $display("FAIL to_flag: timeout/mode=%b required 101", {timeout, cur_mode}); end
        checks++; if (act !== exp_t(1)) begin errors++; $display("FAIL to_timing: got %h required %h", act, exp_t(1)); end
        wait_settled();
        frame_pulse();
        checks++; if ({done, timeout} !== 2'b11) begin errors++; $display("FAIL to_sticky: done/timeout=%b required 11", {done, timeout}); end
        request(2'd2);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b required 0", timeout); end
        frame_pulse();
        checks++; if ({timeout, tg_rst} !== 2'b01) begin errors++; $display("FAIL to_frame_load: timeout/tg=%b required 01", {timeout, tg_rst}); end
        wait_settled();
        frame_pulse();
    endtask

    task automatic test_ignore_in_settle();
        int dones;
        request(2'd3);
        frame_pulse();
        step();
        step();
        @(negedge clk); req = 1'b1; mode = 2'd1;
        @(negedge clk); req = 1'b0;
        wait_settled();
        frame_pulse();
        dones = int'(done);
        for (int i = 0; i < 30; i++) begin
            step();
            dones += int'(done);
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count: got %0d required 1", dones); end
        checks++; if ({cur_mode, ready} !== 3'b111) begin errors++; $display("FAIL ign_mode: mode/ready=%b required 111", {cur_mode, ready}); end
        checks++; if (act !== exp_t(3)) begin errors++; $display("FAIL ign_timing: got %h required %h", act, exp_t(3)); end
    endtask

    task automatic test_reset_mid();
        request(2'd3);
        repeat (3) step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({cur_mode, tg_rst, ready, blank} !== 5'b00101) begin errors++;
            $display("FAIL rm_abort: mode/tg/ready/blank=%b required 00101", {cur_mode, tg_rst, ready, blank}); end
        checks++; if (act !== exp_t(0)) begin errors++; $display("FAIL rm_timing: got %h required %h", act, exp_t(0)); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_settled();
        frame_pulse();
        checks++; if ({done, ready, cur_mode} !== 4'b1100) begin errors++;
            $display("FAIL rm_done: done/ready/mode=%b required 1100", {done, ready, cur_mode}); end
    endtask

    task automatic test_mode1_steady();
        request(2'd1);
        frame_pulse();
        wait_settled();
        frame_pulse();
        request(2'd1);
        frame_pulse();
        checks++; if ({tg_rst, blank} !== 2'b11) begin errors++; $display("FAIL same_mode_seq: tg/blank=%b required 11", {tg_rst, blank}); end
        wait_settled();
        frame_pulse();
        for (int i = 0; i < 50; i++) begin
            frame = (i % 10 == 3);
            step();
            checks++;
            if (tg_rst !== 1'b0 || blank !== 1'b0 || ready !== 1'b1 || act !== exp_t(1)) begin
                errors++;
                $display("FAIL idle_stable[%0d]: tg/blank/ready=%b timing %h required 001 timing %h",
                         i, {tg_rst, blank, ready}, act, exp_t(1));
            end
        end
        frame = 1'b0;
        checks++; if (32'(h_res) + 32'(h_fp) + 32'(h_sync) + 32'(h_bp) !== 32'd1056) begin errors++;
            $display("FAIL h_total: got %0d required 1056", 32'(h_res) + 32'(h_fp) + 32'(h_sync) + 32'(h_bp)); end
        checks++; if (32'(v_res) + 32'(v_fp) + 32'(v_sync) + 32'(v_bp) !== 32'd628) begin errors++;
            $display("FAIL v_total: got %0d required 628", 32'(v_res) + 32'(v_fp) + 32'(v_sync) + 32'(v_bp)); end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_timeout();
        test_ignore_in_settle();
        test_reset_mid();
        test_mode1_steady();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
